// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with barrel shifts and an iterative restoring divider
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int DIV_ENABLE = 1,
  parameter int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             is_zero,
  output logic             is_negative
);

  localparam int HW    = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_keep_q, a_keep_d;
  logic               want_rem_q, want_rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               valid_q, valid_d;

  logic               is_div;
  logic               is_signed;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     ax, bx, cx;
  logic [WIDTH:0]     alu;
  logic [WIDTH:0]     sh_t;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   lo_prod;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   q_fix, r_fix, div_res;
  logic               unused_ok;

  assign is_div    = (DIV_ENABLE != 0) && (op[4:2] == 3'b101);
  assign is_signed = op[1];
  assign amt       = b[SHAMT_W-1:0];
  assign ax        = {1'b0, a};
  assign bx        = {1'b0, b};
  assign cx        = {{WIDTH{1'b0}}, carry_in};
  assign prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign lo_prod   = {{HW{1'b0}}, a[HW-1:0]} * {{HW{1'b0}}, b[HW-1:0]};

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign ge        = rem_shift >= {1'b0, dvs_q};
  assign diff      = rem_shift - {1'b0, dvs_q};

  assign unused_ok = ^{op[7:5], diff[WIDTH]};

  always_comb begin
    alu  = '0;
    sh_t = '0;
    case (op[4:0])
      5'd0:  alu = ax + bx;
      5'd1:  alu = ax + bx + cx;
      5'd2:  alu = ax - bx;
      5'd3:  alu = ax - bx - cx;
      5'd4:  alu = {1'b0, a | b};
      5'd5:  alu = {1'b0, a & b};
      5'd6:  alu = {1'b0, ~a};
      5'd7:  alu = {1'b0, a ^ b};
      5'd8: begin
        if (a < b)       alu = '1;
        else if (a == b) alu = '0;
        else             alu = (WIDTH+1)'(1);
      end
      5'd9:  alu = ax;
      5'd12: alu = {a, 1'b0};
      5'd13: alu = {a[0], 1'b0, a[WIDTH-1:1]};
      5'd14: alu = ax << amt;
      // Right shifts run on {a,0} so the last bit shifted out lands in bit 0.
      5'd15: begin
        sh_t = {a, 1'b0} >> amt;
        alu  = {sh_t[0], sh_t[WIDTH:1]};
      end
      5'd19: begin
        sh_t = $signed({a, 1'b0}) >>> amt;
        alu  = {sh_t[0], sh_t[WIDTH:1]};
      end
      5'd16: alu = {1'b0, lo_prod};
      5'd17: alu = {1'b0, prod[WIDTH-1:0]};
      5'd18: alu = {1'b0, prod[2*WIDTH-1:WIDTH]};
      default: alu = '0;
    endcase
  end

  always_comb begin
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_keep_q;
    end
    div_res = want_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      a_keep_q   <= '0;
      want_rem_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      c_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      a_keep_q   <= a_keep_d;
      want_rem_q <= want_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      c_q        <= c_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    a_keep_d   = a_keep_q;
    want_rem_d = want_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_div) begin
          state_d    = S_DIV;
          count_d    = CNT_W'(WIDTH);
          quo_d      = (is_signed && a[WIDTH-1]) ? -a : a;
          dvs_d      = (is_signed && b[WIDTH-1]) ? -b : b;
          rem_d      = '0;
          a_keep_d   = a;
          want_rem_d = op[0];
          neg_quo_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = is_signed && a[WIDTH-1];
          div0_d     = (b == '0);
        end
      end
      S_DIV: begin
        quo_d   = {quo_q[WIDTH-2:0], ge};
        rem_d   = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c_d     = c_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    valid_d = 1'b0;
    if (state_q == S_IDLE && start && !is_div) begin
      c_d     = alu[WIDTH-1:0];
      carry_d = alu[WIDTH];
      zero_d  = (alu[WIDTH-1:0] == '0);
      neg_d   = alu[WIDTH-1];
      valid_d = 1'b1;
    end else if (state_q == S_FIX) begin
      c_d     = div_res;
      carry_d = div0_q;
      zero_d  = (div_res == '0);
      neg_d   = div_res[WIDTH-1];
      valid_d = 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign valid       = valid_q;
  assign c           = c_q;
  assign carry_out   = carry_q;
  assign is_zero     = zero_q;
  assign is_negative = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=32 and WIDTH=16
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  op;
  logic [31:0] a, b;
  logic        cin;
  logic        start32, start16;

  logic        busy32, valid32, co32, z32, n32;
  logic [31:0] c32;
  logic        busy16, valid16, co16, z16, n16;
  logic [15:0] c16;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
    .carry_in(cin), .busy(busy32), .valid(valid32), .c(c32),
    .carry_out(co32), .is_zero(z32), .is_negative(n32)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op), .a(a[15:0]), .b(b[15:0]),
    .carry_in(cin), .busy(busy16), .valid(valid16), .c(c16),
    .carry_out(co16), .is_zero(z16), .is_negative(n16)
  );

  typedef struct {
    logic [31:0] c;
    logic        co;
    int          lat;
    int          issue;
    int          id;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] cv,
                     input logic co, input logic z, input logic n);
    exp_t e;
    if (v) begin
      if ((w == 32 && q32.size() == 0) || (w == 16 && q16.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL w%0d unexpected_valid: got c=%h expected no valid", w, cv);
      end else begin
        if (w == 32) e = q32.pop_front();
        else         e = q16.pop_front();
        chk($sformatf("w%0d_v%0d_c", w, e.id), cv, e.c);
        chk($sformatf("w%0d_v%0d_carry", w, e.id), {31'b0, co}, {31'b0, e.co});
        chk($sformatf("w%0d_v%0d_zero", w, e.id), {31'b0, z}, {31'b0, e.c == 32'h0});
        chk($sformatf("w%0d_v%0d_neg", w, e.id), {31'b0, n},
            {31'b0, (w == 32) ? e.c[31] : e.c[15]});
        chk($sformatf("w%0d_v%0d_latency", w, e.id), 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) mon(32, valid32, c32, co32, z32, n32);
  always @(negedge clk) mon(16, valid16, {16'h0, c16}, co16, z16, n16);

  task automatic issue(input int w, input int id, input logic [7:0] o,
                       input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic [31:0] ec, input logic eco);
    exp_t e;
    int   n = 0;
    while (((w == 32) ? busy32 : busy16) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL w%0d_v%0d_busy_timeout: got busy=1 expected busy=0", w, id);
    end
    op  = o;
    a   = av;
    b   = bv;
    cin = ci;
    if (w == 32) start32 = 1'b1;
    else         start16 = 1'b1;
    e.c     = ec;
    e.co    = eco;
    e.id    = id;
    e.issue = cyc;
    e.lat   = (o[4:2] == 3'b101) ? w + 2 : 1;
    if (w == 32) q32.push_back(e);
    else         q16.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q32.size() + q16.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset   = 1'b1;
    start32 = 1'b0;
    start16 = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'b0, busy32},  32'h0);
    chk("reset_valid", {31'b0, valid32}, 32'h0);
    chk("reset_c",     c32,              32'h0);
    chk("reset_flags", {29'b0, co32, z32, n32}, 32'h0);
    chk("reset_c16",   {16'h0, c16},     32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single-cycle ops, issued back to back
    issue(32,  1, 8'd1,  32'hFFFFFFFF, 32'h0,        1'b1, 32'h00000000, 1'b1);
    issue(32,  2, 8'd8,  32'h3,        32'h5,        1'b0, 32'hFFFFFFFF, 1'b1);
    issue(32,  3, 8'd19, 32'h80000010, 32'h4,        1'b0, 32'hF8000001, 1'b0);
    issue(32,  4, 8'd14, 32'h1,        32'd31,       1'b0, 32'h80000000, 1'b0);
    issue(32,  5, 8'd15, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    issue(32,  6, 8'd2,  32'h5,        32'h7,        1'b0, 32'hFFFFFFFE, 1'b1);
    issue(32,  7, 8'd3,  32'hA,        32'h3,        1'b1, 32'h00000006, 1'b0);
    issue(32,  8, 8'd7,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0);
    issue(32,  9, 8'd16, 32'hFFFF0003, 32'h12340004, 1'b0, 32'h0000000C, 1'b0);
    issue(32, 10, 8'd17, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b0);
    issue(32, 11, 8'd18, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 1'b0);
    issue(32, 12, 8'd13, 32'h3,        32'h0,        1'b0, 32'h00000001, 1'b1);
    issue(32, 13, 8'd12, 32'h80000001, 32'h0,        1'b0, 32'h00000002, 1'b1);
    issue(32, 14, 8'd10, 32'h12345678, 32'h1,        1'b1, 32'h00000000, 1'b0);
    issue(32, 15, 8'hE9, 32'h12345678, 32'h0,        1'b0, 32'h12345678, 1'b0);
    drain();

    // Signed divide, busy duration, then back-to-back divides
    issue(32, 20, 8'd22, 32'hFFFFFFF9, 32'h2, 1'b0, 32'hFFFFFFFD, 1'b0);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("div_busy_cycles", 32'(n), 32'd33);
    issue(32, 21, 8'd23, 32'hFFFFFFF9, 32'h2,        1'b0, 32'hFFFFFFFF, 1'b0);
    issue(32, 22, 8'd20, 32'h1234,     32'h0,        1'b0, 32'hFFFFFFFF, 1'b1);
    issue(32, 23, 8'd22, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0);
    issue(32, 24, 8'd23, 32'hFFFFFFF9, 32'h0,        1'b0, 32'hFFFFFFF9, 1'b1);
    issue(32, 25, 8'd20, 32'h100,      32'h7,        1'b0, 32'h00000024, 1'b0);
    // Operand churn and ignored start requests while busy
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      a       = $urandom;
      b       = $urandom;
      op      = 8'd0;
      start32 = 1'b1;
      @(negedge clk);
    end
    issue(32, 26, 8'd0, 32'h1, 32'h1, 1'b0, 32'h00000002, 1'b0);
    drain();

    // Reset mid-division aborts without a valid pulse
    op      = 8'd21;
    a       = 32'h100;
    b       = 32'h7;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",  {31'b0, busy32},  32'h0);
    chk("abort_valid", {31'b0, valid32}, 32'h0);
    chk("abort_c",     c32,              32'h0);
    repeat (40) @(negedge clk);
    issue(32, 30, 8'd21, 32'h100, 32'h7, 1'b0, 32'h00000004, 1'b0);
    drain();

    // WIDTH=16 instance
    issue(16, 40, 8'd1,  32'hFFFF, 32'h0,    1'b1, 32'h0000, 1'b1);
    issue(16, 41, 8'd18, 32'hFFFF, 32'hFFFF, 1'b0, 32'hFFFE, 1'b0);
    issue(16, 42, 8'd19, 32'h8010, 32'h4,    1'b0, 32'hF801, 1'b0);
    issue(16, 43, 8'd8,  32'h5,    32'h3,    1'b0, 32'h0001, 1'b0);
    issue(16, 44, 8'd22, 32'hFFF9, 32'h2,    1'b0, 32'hFFFD, 1'b0);
    issue(16, 45, 8'd23, 32'hFFF9, 32'h2,    1'b0, 32'hFFFF, 1'b0);
    issue(16, 46, 8'd20, 32'h1234, 32'h0,    1'b0, 32'hFFFF, 1'b1);
    issue(16, 47, 8'd22, 32'h8000, 32'hFFFF, 1'b0, 32'h8000, 1'b0);
    issue(16, 48, 8'd0,  32'h1,    32'h1,    1'b0, 32'h0002, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    chk("pending_at_end", 32'(q32.size() + q16.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 32-bit combinatorial CPU ALU.
- Same opcode map for ops 0-18, generalised to WIDTH bits, with outputs registered behind a start/valid handshake.
- Adds barrel shifts by a variable amount and an iterative signed/unsigned divider (one quotient bit per cycle).
- Sits between the CPU execute stage and the register file write-back; the CPU stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- DIV_ENABLE, 1, 1 = iterative divider present; 0 = ops 20-23 complete in one cycle with result 0, carry_out 0.
- SHAMT_W, $clog2(WIDTH), width of the shift amount taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  8  opcode; only op[4:0] decoded.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry/borrow for adc/sbc.
- busy  out  1  operation in progress; start ignored while high.
- valid  out  1  one-cycle pulse: c/flags hold a new result.
- c  out  WIDTH  result.
- carry_out  out  1  bit WIDTH of internal WIDTH+1 result; 1 on divide by zero.
- is_zero  out  1  c == 0.
- is_negative  out  1  c[WIDTH-1].

Behaviour:
- Reset: the synchronous, active-high reset forces busy=0, valid=0, c=0, carry_out=0, is_zero=0, is_negative=0, state IDLE. Reset aborts any division in flight with no valid pulse.
- Operand capture: a, b, op and carry_in are latched on the edge where start=1 and busy=0. Later input changes have no effect on that operation.
- Single-cycle ops, all arithmetic WIDTH+1 bits zero-extended:
  - 0 add; 1 adc (add + carry_in); 2 sub; 3 sbc (sub - carry_in).
  - 4 or; 5 and; 6 not a; 7 xor.
  - 8 cmp: all ones if a<b unsigned (carry 1), 0 if equal, else 1.
  - 9 pass a.
  - 12 shl1: {a,0}, carry = a[W-1]; 13 shr1: carry = a[0], c = a>>1.
  - 14 shl by b[SHAMT_W-1:0]; 15 logical shr by amount; 19 arithmetic shr by amount. For 14/15/19, carry = last bit shifted out, 0 if amount 0.
  - 16 lo-half product: a[W/2-1:0]*b[W/2-1:0], carry 0.
  - 17 full product low WIDTH bits; 18 full product high WIDTH bits (unsigned).
  - All other codes: result 0, carry 0.
- Single-cycle timing: the result is registered on the start edge, valid=1 for exactly the next cycle, busy stays 0.
- Divide ops (DIV_ENABLE=1): 20 divu quotient; 21 remu remainder; 22 div signed quotient (truncating); 23 rem signed remainder (sign follows a).
- FSM IDLE -> DIV -> FIX -> IDLE.
  - IDLE: a start with a divide op loads the operands (magnitudes for signed) and count=WIDTH, busy=1.
  - DIV: one restoring step per cycle, count decrements; at count==0 go to FIX.
  - FIX: apply sign correction, register c and flags, valid=1 in the following cycle, busy=0 in that same cycle.
- Divide latency: valid is high exactly WIDTH+2 cycles after the start edge (cycle 1 = first after start).
- Back-to-back: a start is accepted in the cycle valid is high, because busy is already 0.
- Divide by zero: quotient all ones, remainder = a, carry_out=1. Same latency; the fast path is not allowed.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder 0, carry_out=0.
- Flags: is_zero and is_negative always track the registered c. carry_out is 0 for ops 20-23 except divide by zero.
- Outputs hold their value between operations; valid alone marks freshness.

Test Plan:
- WIDTH=32, op=1, a=FFFFFFFF, b=0, carry_in=1 -> next cycle valid=1, c=0, carry_out=1, is_zero=1. Then op=8, a=3, b=5 -> c=FFFFFFFF, carry_out=1, is_negative=1.
- op=19, a=80000010, b=4 -> c=F8000001, carry_out=0. op=14, a=1, b=31 -> c=80000000. op=15 with b=0 -> c=a, carry_out=0.
- op=22, a=FFFFFFF9 (-7), b=2 -> busy for 33 cycles, valid at cycle 34, c=FFFFFFFD (-3). op=23 with the same operands -> c=FFFFFFFF (-1).
- op=20, a=1234, b=0 -> c=FFFFFFFF, carry_out=1. op=22, a=80000000, b=FFFFFFFF -> c=80000000, carry_out=0.
- op=20, a=100, b=7 -> change a/b while busy: result still 24 (0x24). Assert start in the valid cycle with op=0, a=1, b=1 -> accepted, c=2 one cycle later.
- Start op=21, assert reset at cycle 10 -> busy=0, c=0, no valid pulse. A start after reset completes normally.
- Repeat the test plan with WIDTH=16: op=18, a=FFFF, b=FFFF -> c=FFFE.
